uart_rx_byte: RTL and testbench

//  8N1 UART receiver: deserialises the line driven into the CPU's Rx pin.

---
 rtl/uart_rx_byte_if.sv | 29 ++
 rtl/uart_rx_byte.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: holding-register side of the 8N1 UART receiver.
// master = receiver (drives byte + status flags), slave = consumer (drives in_Ack).
// Signals: out_DataByte[7:0], out_fValid, in_Ack, out_fFrameErr, out_fOverrun, out_fBusy.
interface uart_rx_byte_if;
  logic [7:0] out_DataByte;
  logic       out_fValid;
  logic       in_Ack;
  logic       out_fFrameErr;
  logic       out_fOverrun;
  logic       out_fBusy;

  modport master (
    output out_DataByte,
    output out_fValid,
    output out_fFrameErr,
    output out_fOverrun,
    output out_fBusy,
    input  in_Ack
  );

  modport slave (
    input  out_DataByte,
    input  out_fValid,
    input  out_fFrameErr,
    input  out_fOverrun,
    input  out_fBusy,
    output in_Ack
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver presenting each byte in a holding register.
// Latency: ~2 clk synchroniser + 9.5*KBAUD from start edge to out_fValid
//   (+1 clk when UART_RX_MAJORITY_EN is defined).
// Backpressure: none on the line; an unacknowledged byte is overwritten and
//   out_fOverrun is set until the next in_Ack.
// Ports: clk, rst_n (async active-low), in_Rx (async serial line, idle high),
//   rx_if (master modport): out_DataByte, out_fValid, in_Ack, out_fFrameErr,
//   out_fOverrun, out_fBusy.
// Option: UART_RX_MAJORITY_EN -> 2-of-3 vote around each bit centre.
module uart_rx_byte #(
  parameter logic [13:0] KBAUD = 14'd10416
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_Rx,
  uart_rx_byte_if.master rx_if
);

  localparam logic [13:0] HALF    = KBAUD >> 1;
  localparam logic [13:0] BIT_END = KBAUD - 14'd1;
`ifdef UART_RX_MAJORITY_EN
  // Vote needs the cycle after the centre, so every decision moves +1 clk.
  localparam logic [13:0] START_PT = HALF;
`else
  localparam logic [13:0] START_PT = HALF - 14'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, rx_prev_q;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_s;
  logic        samp;
  logic        ack_take;

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev2_q <= 1'b1;
    end else begin
      rx_prev2_q <= rx_prev_q;
    end
  end

  // rx_s = centre+1, rx_prev_q = centre, rx_prev2_q = centre-1.
  assign samp = (rx_s & rx_prev_q) | (rx_s & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  assign samp = rx_s;
`endif

  // Synchroniser and edge history are preset to the idle level so reset
  // release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= in_Rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ack_take = rx_if.in_Ack & valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (ack_take) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == START_PT) begin
          cnt_d = '0;
          if (samp) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = samp;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (samp) begin
            // A simultaneous ack consumes the old byte, so no overrun then.
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_if.in_Ack) begin
              ovr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_if.out_DataByte  = data_q;
  assign rx_if.out_fValid    = valid_q;
  assign rx_if.out_fFrameErr = ferr_q;
  assign rx_if.out_fOverrun  = ovr_q;
  assign rx_if.out_fBusy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: bench for uart_rx_byte with KBAUD=16.
// Table of frames with constant expectations, hand-written corner sequences,
// then random frames checked against a holding-register model.
module tb_uart_rx_byte;
  localparam int KB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic in_Rx;

  uart_rx_byte_if rx_if();

  uart_rx_byte #(.KBAUD(14'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_Rx (in_Rx),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;

  // Counts high cycles, so a pulse wider than one clock inflates the count.
  always @(negedge clk) begin
    if (rx_if.out_fFrameErr === 1'b1) ferr_cnt++;
  end

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic       ack;
    logic [7:0] e_dat;
    logic       e_vld;
    logic       e_ovr;
    int         e_fe;
  } vec_t;

  vec_t vec[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_Rx = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic v, input int glitch_at);
    for (int i = 0; i < KB; i++) begin
      @(negedge clk);
      in_Rx = (i == glitch_at) ? ~v : v;
    end
  endtask

  // ack_lo..ack_hi: stop-bit clock indices during which in_Ack is held high.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch0,
                            input int ack_lo, input int ack_hi);
    drive_bit(1'b0, -1);
    for (int k = 0; k < 8; k++) drive_bit(b[k], (k == 0) ? glitch0 : -1);
    for (int i = 0; i < KB; i++) begin
      @(negedge clk);
      in_Rx = stop;
      rx_if.in_Ack = (i >= ack_lo) && (i <= ack_hi);
    end
    rx_if.in_Ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_if.in_Ack = 1'b1;
    @(negedge clk);
    rx_if.in_Ack = 1'b0;
  endtask

  int         f0;
  int         ack_at;
  logic [7:0] exp_g;
  logic [7:0] b;
  logic       stop;
  logic       ackit;
  logic [7:0] m_dat;
  logic       m_vld;
  logic       m_ovr;
  int         m_fe;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'h46, 1'b1, 1'b0, 8'h46, 1'b1, 1'b0, 0};
    vec[1] = '{8'h49, 1'b1, 1'b1, 8'h49, 1'b1, 1'b1, 0};
    vec[2] = '{8'h0A, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 0};
    vec[3] = '{8'h55, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0, 1};
    vec[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vec[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
    vec[6] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vec[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 0};

`ifdef UART_RX_MAJORITY_EN
    exp_g  = 8'h46;
    ack_at = 11;
`else
    exp_g  = 8'h47;
    ack_at = 10;
`endif

    in_Rx = 1'b1;
    rx_if.in_Ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rx_if.out_DataByte),  32'h0);
    chk("rst_valid", 32'(rx_if.out_fValid),    32'h0);
    chk("rst_ferr",  32'(rx_if.out_fFrameErr), 32'h0);
    chk("rst_ovr",   32'(rx_if.out_fOverrun),  32'h0);
    chk("rst_busy",  32'(rx_if.out_fBusy),     32'h0);
    rst_n = 1'b1;
    idle(5);

    // Table-driven frames.
    for (int t = 0; t < 8; t++) begin
      f0 = ferr_cnt;
      send_frame(vec[t].tx, vec[t].stop, -1, -1, -1);
      idle(6);
      chk($sformatf("vec%0d_data", t), 32'(rx_if.out_DataByte), 32'(vec[t].e_dat));
      chk($sformatf("vec%0d_valid", t), 32'(rx_if.out_fValid), 32'(vec[t].e_vld));
      chk($sformatf("vec%0d_ovr", t), 32'(rx_if.out_fOverrun), 32'(vec[t].e_ovr));
      chk($sformatf("vec%0d_ferr", t), 32'(ferr_cnt - f0), 32'(vec[t].e_fe));
      if (vec[t].ack) begin
        do_ack();
        idle(2);
        chk($sformatf("vec%0d_valid_after_ack", t), 32'(rx_if.out_fValid), 32'h0);
        chk($sformatf("vec%0d_ovr_after_ack", t), 32'(rx_if.out_fOverrun), 32'h0);
      end
    end

    // False start: 4 clocks low while idle.
    f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_Rx = 1'b0;
    end
    @(negedge clk);
    in_Rx = 1'b1;
    chk("false_start_busy_hi", 32'(rx_if.out_fBusy), 32'h1);
    idle(30);
    chk("false_start_busy_lo", 32'(rx_if.out_fBusy), 32'h0);
    chk("false_start_valid", 32'(rx_if.out_fValid), 32'h0);
    chk("false_start_ferr", 32'(ferr_cnt - f0), 32'h0);

    // Bad stop bit followed by 3 bit times of break, then a good byte.
    f0 = ferr_cnt;
    send_frame(8'h49, 1'b0, -1, -1, -1);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, -1);
    chk("break_busy", 32'(rx_if.out_fBusy), 32'h1);
    chk("break_valid", 32'(rx_if.out_fValid), 32'h0);
    idle(6);
    chk("break_idle", 32'(rx_if.out_fBusy), 32'h0);
    send_frame(8'h0A, 1'b1, -1, -1, -1);
    idle(6);
    chk("break_ferr", 32'(ferr_cnt - f0), 32'h1);
    chk("break_next_data", 32'(rx_if.out_DataByte), 32'h0A);
    chk("break_next_valid", 32'(rx_if.out_fValid), 32'h1);

    // Ack on the very cycle the next byte loads: byte kept, no overrun.
    send_frame(8'h3C, 1'b1, -1, ack_at, ack_at);
    idle(6);
    chk("load_ack_data", 32'(rx_if.out_DataByte), 32'h3C);
    chk("load_ack_valid", 32'(rx_if.out_fValid), 32'h1);
    chk("load_ack_ovr", 32'(rx_if.out_fOverrun), 32'h0);
    do_ack();
    idle(2);

    // One-clock high glitch at the centre of bit 0.
    send_frame(8'h46, 1'b1, 8, -1, -1);
    idle(6);
    chk("glitch_data", 32'(rx_if.out_DataByte), 32'(exp_g));
    chk("glitch_valid", 32'(rx_if.out_fValid), 32'h1);

    // Reset during bit 3 of a frame, held until the frame is over.
    fork
      send_frame(8'h46, 1'b1, -1, -1, -1);
      begin
        repeat (KB * 4 + KB / 2) @(negedge clk);
        chk("midrst_busy_before", 32'(rx_if.out_fBusy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_data",  32'(rx_if.out_DataByte),  32'h0);
        chk("midrst_valid", 32'(rx_if.out_fValid),    32'h0);
        chk("midrst_ferr",  32'(rx_if.out_fFrameErr), 32'h0);
        chk("midrst_ovr",   32'(rx_if.out_fOverrun),  32'h0);
        chk("midrst_busy",  32'(rx_if.out_fBusy),     32'h0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h0A, 1'b1, -1, -1, -1);
    idle(6);
    chk("after_rst_data", 32'(rx_if.out_DataByte), 32'h0A);
    chk("after_rst_valid", 32'(rx_if.out_fValid), 32'h1);
    chk("after_rst_ovr", 32'(rx_if.out_fOverrun), 32'h0);

    // Random frames against a holding-register model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    m_dat = 8'h00;
    m_vld = 1'b0;
    m_ovr = 1'b0;
    m_fe  = ferr_cnt;
    for (int n = 0; n < 40; n++) begin
      b     = 8'($urandom_range(0, 255));
      stop  = ($urandom_range(0, 5) != 0);
      ackit = 1'($urandom_range(0, 1));
      send_frame(b, stop, -1, -1, -1);
      idle($urandom_range(3, 12));
      if (stop) begin
        m_ovr = m_ovr | m_vld;
        m_dat = b;
        m_vld = 1'b1;
      end else begin
        m_fe++;
      end
      chk($sformatf("rnd%0d_data", n), 32'(rx_if.out_DataByte), 32'(m_dat));
      chk($sformatf("rnd%0d_valid", n), 32'(rx_if.out_fValid), 32'(m_vld));
      chk($sformatf("rnd%0d_ovr", n), 32'(rx_if.out_fOverrun), 32'(m_ovr));
      chk($sformatf("rnd%0d_ferr", n), 32'(ferr_cnt), 32'(m_fe));
      if (ackit) begin
        do_ack();
        m_vld = 1'b0;
        m_ovr = 1'b0;
      end
      idle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
